// File: rtl/deal_cards.sv
// deal_cards: deals ten pairwise-distinct playing cards from a free-running 16-bit LFSR
// and commits all ten at once. Defining DEAL_JOKER_EN enables the single-joker variant.
module deal_cards #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_c,
    input  logic        deal_s,
    output logic [3:0]  Pnum0,
    output logic [3:0]  Pnum1,
    output logic [3:0]  Pnum2,
    output logic [3:0]  Pnum3,
    output logic [3:0]  Pnum4,
    output logic [3:0]  Pnum5,
    output logic [3:0]  Pnum6,
    output logic [3:0]  Pnum7,
    output logic [3:0]  Pnum8,
    output logic [3:0]  Pnum9,
    output logic [2:0]  suit0,
    output logic [2:0]  suit1,
    output logic [2:0]  suit2,
    output logic [2:0]  suit3,
    output logic [2:0]  suit4,
    output logic [2:0]  suit5,
    output logic [2:0]  suit6,
    output logic [2:0]  suit7,
    output logic [2:0]  suit8,
    output logic [2:0]  suit9,
    output logic        busy,
    output logic        deal_done,
    output logic [15:0] dbg_lfsr,
    output logic [3:0]  dbg_k,
    output logic        dbg_state
);

    // Handshake: deal_s is a level request sampled only while idle; busy is high from the
    // edge that accepts the request until the commit edge, where deal_done pulses for one
    // cycle and the ten card outputs become valid and stay stable until the next commit.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  k_q, k_d;
    logic        done_q, done_d;

    logic [3:0]  stg_num_q  [0:8];
    logic [3:0]  stg_num_d  [0:8];
    logic [2:0]  stg_suit_q [0:8];
    logic [2:0]  stg_suit_d [0:8];
    logic [3:0]  out_num_q  [0:9];
    logic [3:0]  out_num_d  [0:9];
    logic [2:0]  out_suit_q [0:9];
    logic [2:0]  out_suit_d [0:9];

    logic [3:0]  cand_num;
    logic [2:0]  cand_suit;
    logic        cand_rank_ok;
    logic        cand_dup;
    logic        cand_ok;

    always_comb begin
        cand_num     = lfsr_q[3:0];
        cand_suit    = {1'b0, lfsr_q[5:4]};
        cand_rank_ok = (cand_num != 4'd0) && (cand_num <= 4'd13);
`ifdef DEAL_JOKER_EN
        // A zero rank with bit 6 set is the joker; the duplicate check limits it to one per deal.
        if ((cand_num == 4'd0) && lfsr_q[6]) begin
            cand_suit    = 3'd4;
            cand_rank_ok = 1'b1;
        end
`endif
    end

    always_comb begin
        cand_dup = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if ((4'(j) < k_q) && (stg_num_q[j] == cand_num) && (stg_suit_q[j] == cand_suit)) begin
                cand_dup = 1'b1;
            end
        end
    end

    assign cand_ok = cand_rank_ok && !cand_dup;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        done_d     = 1'b0;
        stg_num_d  = stg_num_q;
        stg_suit_d = stg_suit_q;
        out_num_d  = out_num_q;
        out_suit_d = out_suit_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            S_IDLE: begin
                if (deal_s) begin
                    k_d     = 4'd0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (cand_ok) begin
                    if (k_q == 4'd9) begin
                        // Final accept: staging and the tenth card go out together.
                        for (int i = 0; i < 9; i++) begin
                            out_num_d[i]  = stg_num_q[i];
                            out_suit_d[i] = stg_suit_q[i];
                        end
                        out_num_d[9]  = cand_num;
                        out_suit_d[9] = cand_suit;
                        done_d        = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            if (4'(i) == k_q) begin
                                stg_num_d[i]  = cand_num;
                                stg_suit_d[i] = cand_suit;
                            end
                        end
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_c) begin
        if (!reset_c) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            k_q     <= 4'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                stg_num_q[i]  <= 4'd0;
                stg_suit_q[i] <= 3'd0;
            end
            for (int i = 0; i < 10; i++) begin
                out_num_q[i]  <= 4'd0;
                out_suit_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            k_q        <= k_d;
            done_q     <= done_d;
            stg_num_q  <= stg_num_d;
            stg_suit_q <= stg_suit_d;
            out_num_q  <= out_num_d;
            out_suit_q <= out_suit_d;
        end
    end

    assign busy      = (state_q == S_DRAW);
    assign deal_done = done_q;
    assign dbg_lfsr  = lfsr_q;
    assign dbg_k     = k_q;
    assign dbg_state = state_q;

    assign Pnum0 = out_num_q[0];
    assign Pnum1 = out_num_q[1];
    assign Pnum2 = out_num_q[2];
    assign Pnum3 = out_num_q[3];
    assign Pnum4 = out_num_q[4];
    assign Pnum5 = out_num_q[5];
    assign Pnum6 = out_num_q[6];
    assign Pnum7 = out_num_q[7];
    assign Pnum8 = out_num_q[8];
    assign Pnum9 = out_num_q[9];

    assign suit0 = out_suit_q[0];
    assign suit1 = out_suit_q[1];
    assign suit2 = out_suit_q[2];
    assign suit3 = out_suit_q[3];
    assign suit4 = out_suit_q[4];
    assign suit5 = out_suit_q[5];
    assign suit6 = out_suit_q[6];
    assign suit7 = out_suit_q[7];
    assign suit8 = out_suit_q[8];
    assign suit9 = out_suit_q[9];

endmodule

// File: tb/tb_deal_cards.sv
// tb_deal_cards: randomized deals checked against a transaction-level card-dealing model.
// Compile with DEAL_JOKER_EN defined to exercise the joker build.
module tb_deal_cards;

    localparam logic [15:0] SEED = 16'hACE1;
`ifdef DEAL_JOKER_EN
    localparam int N_RAND = 1000;
`else
    localparam int N_RAND = 100;
`endif

    logic        clock = 1'b0;
    logic        reset_c = 1'b0;
    logic        deal_s = 1'b0;
    logic [3:0]  Pnum0, Pnum1, Pnum2, Pnum3, Pnum4, Pnum5, Pnum6, Pnum7, Pnum8, Pnum9;
    logic [2:0]  suit0, suit1, suit2, suit3, suit4, suit5, suit6, suit7, suit8, suit9;
    logic        busy, deal_done;
    logic [15:0] dbg_lfsr;
    logic [3:0]  dbg_k;
    logic        dbg_state;
    logic [69:0] dut_cards;

    deal_cards #(.LFSR_SEED(SEED)) dut (
        .clock(clock), .reset_c(reset_c), .deal_s(deal_s),
        .Pnum0(Pnum0), .Pnum1(Pnum1), .Pnum2(Pnum2), .Pnum3(Pnum3), .Pnum4(Pnum4),
        .Pnum5(Pnum5), .Pnum6(Pnum6), .Pnum7(Pnum7), .Pnum8(Pnum8), .Pnum9(Pnum9),
        .suit0(suit0), .suit1(suit1), .suit2(suit2), .suit3(suit3), .suit4(suit4),
        .suit5(suit5), .suit6(suit6), .suit7(suit7), .suit8(suit8), .suit9(suit9),
        .busy(busy), .deal_done(deal_done),
        .dbg_lfsr(dbg_lfsr), .dbg_k(dbg_k), .dbg_state(dbg_state)
    );

    assign dut_cards = {Pnum9, suit9, Pnum8, suit8, Pnum7, suit7, Pnum6, suit6, Pnum5, suit5,
                        Pnum4, suit4, Pnum3, suit3, Pnum2, suit2, Pnum1, suit1, Pnum0, suit0};

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [15:0] m_lfsr = SEED;
    int          edge_no = 0;
    bit          exp_busy = 0;
    int          m_done_edge = 0;
    logic [69:0] exp_q[$];
    int          exp_edge_q[$];

    // Monitor state
    logic [69:0] m_held = '0;
    int          done_cnt = 0;
    int          done_edges[$];
    logic [69:0] last_cards = '0;
    int          last_edge = 0;

    task automatic chk(input bit ok, input string name, input logic [69:0] act, input logic [69:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic bit card_of(input logic [15:0] v, output logic [6:0] card);
        int r;
        r = int'(v[3:0]);
        card = {v[3:0], 1'b0, v[5:4]};
        if (r >= 1 && r <= 13) return 1'b1;
`ifdef DEAL_JOKER_EN
        if (r == 0 && v[6]) begin
            card = {4'd0, 3'd4};
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // Deal from the lfsr value present when the request is accepted: keep drawing until
    // ten distinct valid cards are collected; one candidate is examined per cycle.
    function automatic void model_deal(input logic [15:0] l0, output logic [69:0] cards, output int cycles);
        logic [15:0] v;
        logic [6:0]  got[$];
        logic [6:0]  c;
        bit          seen;
        v = l0;
        cycles = 0;
        cards = '0;
        while (got.size() < 10 && cycles < 70000) begin
            v = lfsr_step(v);
            cycles++;
            if (card_of(v, c)) begin
                seen = 1'b0;
                foreach (got[i]) if (got[i] == c) seen = 1'b1;
                if (!seen) got.push_back(c);
            end
        end
        foreach (got[i]) cards[i*7 +: 7] = got[i];
    endfunction

    // Reference model: advances at every rising edge.
    initial begin
        logic [69:0] cards;
        int          cyc;
        forever begin
            @(posedge clock);
            if (!reset_c) begin
                m_lfsr   = SEED;
                edge_no  = 0;
                exp_busy = 0;
                exp_q.delete();
                exp_edge_q.delete();
            end else begin
                if (exp_busy) begin
                    if (edge_no == m_done_edge) exp_busy = 0;
                end else if (deal_s) begin
                    model_deal(m_lfsr, cards, cyc);
                    exp_q.push_back(cards);
                    exp_edge_q.push_back(edge_no + cyc);
                    m_done_edge = edge_no + cyc;
                    exp_busy = 1;
                end
                m_lfsr = lfsr_step(m_lfsr);
                edge_no++;
            end
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        logic [69:0] exp_c;
        int          exp_e;
        int          jokers;
        bit          dist_ok, range_ok;
        forever begin
            @(negedge clock);
            if (!reset_c) begin
                m_held = '0;
                chk(dut_cards == '0, "reset_cards", dut_cards, '0);
                chk(!busy && !deal_done, "reset_flags", {68'd0, busy, deal_done}, '0);
            end else begin
                chk(busy == exp_busy, "busy", 70'(busy), 70'(exp_busy));
                chk(dbg_lfsr == m_lfsr, "lfsr", 70'(dbg_lfsr), 70'(m_lfsr));
                if (deal_done) begin
                    done_cnt++;
                    last_edge = edge_no - 1;
                    last_cards = dut_cards;
                    done_edges.push_back(last_edge);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_done", 70'(last_edge), '0);
                    end else begin
                        exp_c = exp_q.pop_front();
                        exp_e = exp_edge_q.pop_front();
                        chk(dut_cards == exp_c, "cards", dut_cards, exp_c);
                        chk(last_edge == exp_e, "done_edge", 70'(last_edge), 70'(exp_e));
                        m_held = exp_c;
                    end
                    dist_ok = 1'b1;
                    range_ok = 1'b1;
                    jokers = 0;
                    for (int i = 0; i < 10; i++) begin
                        for (int j = i + 1; j < 10; j++)
                            if (dut_cards[i*7 +: 7] == dut_cards[j*7 +: 7]) dist_ok = 1'b0;
                        if (dut_cards[i*7 +: 3] == 3'd4) begin
                            jokers++;
                            if (dut_cards[i*7+3 +: 4] != 4'd0) range_ok = 1'b0;
                        end else if (dut_cards[i*7 +: 3] > 3'd3 || dut_cards[i*7+3 +: 4] == 4'd0 ||
                                     dut_cards[i*7+3 +: 4] > 4'd13) begin
                            range_ok = 1'b0;
                        end
                    end
`ifndef DEAL_JOKER_EN
                    if (jokers != 0) range_ok = 1'b0;
`endif
                    chk(dist_ok, "distinct", dut_cards, '0);
                    chk(range_ok && jokers <= 1, "range", dut_cards, 70'(jokers));
                end else begin
                    chk(dut_cards == m_held, "hold", dut_cards, m_held);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        reset_c = 1'b0;
        deal_s = 1'b0;
        step(3);
        reset_c = 1'b1;
        chk(dbg_lfsr == SEED, "seed", 70'(dbg_lfsr), 70'(SEED));
    endtask

    task automatic pulse_deal(input int len);
        deal_s = 1'b1;
        step(len);
        deal_s = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk(done_cnt >= target, "timeout", 70'(done_cnt), 70'(target));
    endtask

    initial begin
        logic [69:0] r1_cards;
        int          r1_edge, base, d0, d1, d2;

        do_reset();

        // Single deal, then hold outputs for 100 cycles.
        step(5);
        base = done_cnt;
        pulse_deal(1);
        wait_done(base + 1, 2000);
        step(100);

        // Reproducibility across identical resets.
        do_reset();
        step(5);
        base = done_cnt;
        pulse_deal(1);
        wait_done(base + 1, 2000);
        r1_cards = last_cards;
        r1_edge = last_edge;
        do_reset();
        step(5);
        base = done_cnt;
        pulse_deal(1);
        wait_done(base + 1, 2000);
        chk(last_cards == r1_cards, "repro_cards", last_cards, r1_cards);
        chk(last_edge == r1_edge, "repro_edge", 70'(last_edge), 70'(r1_edge));

        // Request repeated during busy is ignored.
        step(3);
        base = done_cnt;
        pulse_deal(1);
        step(3);
        pulse_deal(1);
        wait_done(base + 1, 2000);
        step(30);
        chk(done_cnt == base + 1, "ignored_req", 70'(done_cnt), 70'(base + 1));

        // Held request yields back-to-back deals.
        base = done_cnt;
        deal_s = 1'b1;
        wait_done(base + 3, 6000);
        deal_s = 1'b0;
        step(30);
        chk(done_cnt == base + 3, "held_count", 70'(done_cnt), 70'(base + 3));
        if (done_edges.size() >= 3) begin
            d0 = done_edges[done_edges.size() - 3];
            d1 = done_edges[done_edges.size() - 2];
            d2 = done_edges[done_edges.size() - 1];
            chk((d1 - d0) >= 11 && (d2 - d1) >= 11, "held_spacing", 70'(d1 - d0), 70'(d2 - d1));
        end

        // Randomized requests.
        for (int n = 0; n < N_RAND; n++) begin
            step($urandom_range(0, 20));
            base = done_cnt;
            pulse_deal($urandom_range(1, 3));
            wait_done(base + 1, 2000);
        end

        // Abort mid-deal with reset.
        step(4);
        base = done_cnt;
        pulse_deal(1);
        step(1);
        reset_c = 1'b0;
        step(3);
        reset_c = 1'b1;
        step(40);
        chk(done_cnt == base, "abort_no_done", 70'(done_cnt), 70'(base));
        chk(dut_cards == '0, "abort_cards", dut_cards, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached, done_cnt=%0d", done_cnt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deal_cards.md
# deal_cards

Dealer stage directly upstream of the draw/hold stage. On a deal request it generates ten distinct playing cards from a free-running LFSR. Slots 0–4 form the opening hand; slots 5–9 are the replacement cards for slots 0–4. All ten card outputs are committed together in one cycle and then held stable for the downstream stage.

## Interface
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
- clock  input  1  system clock, rising edge
- reset_c  input  1  asynchronous active-low reset
- deal_s  input  1  deal request, level-sampled in IDLE
- Pnum0..Pnum9  output  4 each  card rank, 1..13 (0 = joker when enabled)
- suit0..suit9  output  3 each  card suit, 0..3 (4 = joker when enabled)
- busy  output  1  high while a deal is in progress
- deal_done  output  1  one-cycle pulse; outputs valid from this cycle

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR that advances every clock, including in IDLE.
  - Next value: {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- **Candidate card** (combinational from the current lfsr):
  - cnum = lfsr[3:0], csuit = {1'b0, lfsr[5:4]}.
  - Rejected if cnum==0 or cnum>13 (joker exception: see Configuration).
  - Rejected if (cnum, csuit) equals any staging slot j<k, where k is the 4-bit fill index.
- **States**
  - IDLE: busy=0. At an edge with deal_s=1: k←0, go to DRAW, busy←1.
  - DRAW, candidate accepted with k<9: staging slot k ← candidate, k←k+1.
  - DRAW, candidate rejected: no change; retry on the next cycle with the new lfsr.
  - DRAW, candidate accepted with k==9:
    - Pnum0..8/suit0..8 ← staging slots 0..8; Pnum9/suit9 ← candidate, all at the same edge.
    - deal_done←1, busy←0, go to IDLE.
- **Outputs between deals**
  - deal_done is high for exactly one cycle.
  - Card outputs hold their values until the next commit; partial staging is never visible.
- deal_s while in DRAW is ignored.
- deal_s still high in the cycle where deal_done is high starts a new deal at the next edge.
- Duplicate check covers the full rank+suit pair; the ten committed cards are pairwise distinct.

## Timing
- Reset values:
  - all Pnum=0, all suit=0, busy=0, deal_done=0, state=IDLE, k=0, lfsr=LFSR_SEED.
  - Staging slots are cleared to 0.
- Reset asserted mid-deal aborts immediately to reset values; no commit occurs.
- Latency:
  - deal_s sampled at edge N → busy high after N.
  - Accepts occur at edges ≥N+1.
  - Minimum case: commit and deal_done after edge N+10.
  - Each rejection adds one cycle.
- No bound on retries is enforced. LFSR period 65535 guarantees progress.

## Configuration
- DEAL_JOKER_EN, when defined:
  - A candidate with cnum==0 and lfsr[6]==1 becomes the joker (num 0, suit 3'd4). At most one joker per deal, enforced by the duplicate check.
  - cnum==0 with lfsr[6]==0 is rejected.
- Undefined: cnum==0 is always rejected; suit outputs never exceed 3.

## Test plan
- **Reset:** reset_c low mid-run → all Pnum/suit=0, busy=0, deal_done=0. Release with LFSR_SEED=16'hACE1 → the first lfsr value seen is 16'hACE1.
- **Single deal:** one-cycle deal_s → busy for ≥10 cycles; deal_done high exactly 1 cycle.
  - Ten (Pnum,suit) pairs pairwise distinct; Pnum in 1..13, suit in 0..3.
  - Outputs unchanged for 100 cycles afterwards.
- **Reproducibility:** reset, wait 5 cycles, deal; repeat identically → bit-identical ten cards and identical deal_done cycle.
- **Ignored request:** deal_s pulsed again during busy → no restart, exactly one deal_done.
- **Held request:** deal_s held high for 3 deals → three deal_done pulses.
  - Each pulse follows the previous one by ≥11 cycles.
  - Each set is internally distinct.
- **Abort, then joker build:**
  - reset_c low 2 cycles after deal_s → no deal_done, outputs stay 0.
  - With DEAL_JOKER_EN over 1000 deals: ≤1 card with suit 4 per deal, and every such card has Pnum 0.
